// File: rtl/cache_pkg.sv
// Shared types and line geometry for the write-back data cache.
// Imported by the line store, the cache top and its interfaces' users.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_OFF_W     = 2;
  localparam int MEM_ADDR_W     = 28;

  function automatic logic [31:0] line_word(
    input logic [LINE_W-1:0]     line,
    input logic [WORD_OFF_W-1:0] w
  );
    return line[{w, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// Core-side and memory-side handshake bundles of the data cache.
// Core drives requests; the cache masters the line-wide memory bus.
interface dcache_proc_if;
  logic        proc_read;
  logic        proc_write;
  logic [29:0] proc_addr;
  logic [31:0] proc_wdata;
  logic        proc_stall;
  logic [31:0] proc_rdata;

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata,
    input  proc_stall, proc_rdata
  );

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata,
    output proc_stall, proc_rdata
  );
endinterface

interface dcache_mem_if;
  logic                              mem_read;
  logic                              mem_write;
  logic [cache_pkg::MEM_ADDR_W-1:0]  mem_addr;
  logic [cache_pkg::LINE_W-1:0]      mem_wdata;
  logic [cache_pkg::LINE_W-1:0]      mem_rdata;
  logic                              mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays of a direct-mapped cache.
// Combinational read of one line; word write, line fill, dirty clear.
module dcache_line_store
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IW        = 3,
  parameter int TAG_W     = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IW-1:0]         index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_W-1:0]     rd_line,
  input  logic                  wr_en,
  input  logic [WORD_OFF_W-1:0] wr_word,
  input  logic [31:0]           wr_data,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [LINE_W-1:0]     fill_line,
  input  logic                  clean_en
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_line  = data_q[index];

  // Line status bits: cleared by reset, set by fill, dirtied by writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_en) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (clean_en) begin
        dirty_q[index] <= 1'b0;
      end else if (wr_en) begin
        dirty_q[index] <= 1'b1;
      end
    end
  end

  // Tag and data payload; contents only matter once valid is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_line;
    end else if (wr_en) begin
      data_q[index][{wr_word, 5'b0} +: 32] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back write-allocate cache; optional counters
// under DCACHE_STATS_EN (hit, miss, write-back).
module dcache_wb
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int TAG_W     = 28 - $clog2(NUM_LINES)
) (
  input  logic          clk,
  input  logic          rst_n,
  dcache_proc_if.slave  proc,
  dcache_mem_if.master  mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   stat_hit,
  output logic [31:0]   stat_miss,
  output logic [31:0]   stat_wb
`endif
);

  localparam int IW = $clog2(NUM_LINES);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_WB    = WRITEBACK;
  localparam logic [1:0] S_ALLOC = ALLOCATE;

  logic [1:0]            state;
  logic [1:0]            state_d;
  logic                  req;
  logic                  hit;
  logic [IW-1:0]         index;
  logic [TAG_W-1:0]      tag;
  logic [WORD_OFF_W-1:0] word;
  logic                  rd_valid;
  logic                  rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_W-1:0]     rd_line;
  logic                  wr_en;
  logic                  fill_en;
  logic                  clean_en;
  logic                  in_idle;

  assign word  = proc.proc_addr[1:0];
  assign index = proc.proc_addr[IW+1:2];
  assign tag   = proc.proc_addr[29:IW+2];

  assign req     = proc.proc_read | proc.proc_write;
  assign hit     = rd_valid & (rd_tag == tag);
  assign in_idle = (state == S_IDLE);

  assign wr_en    = in_idle & proc.proc_write & hit;
  assign fill_en  = (state == S_ALLOC) & mem.mem_ready;
  assign clean_en = (state == S_WB) & mem.mem_ready;

  dcache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IW        (IW),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .index     (index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (wr_en),
    .wr_word   (word),
    .wr_data   (proc.proc_wdata),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_line (mem.mem_rdata),
    .clean_en  (clean_en)
  );

  // Next state: a miss evicts a dirty victim before refilling.
  always_comb begin
    state_d = state;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (req && !hit)
          state_d = (rd_valid && rd_dirty) ? S_WB : S_ALLOC;
      end
      (state == S_WB): begin
        if (mem.mem_ready) state_d = S_ALLOC;
      end
      (state == S_ALLOC): begin
        if (mem.mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any memory transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Core and memory outputs, zero whenever not in use.
  always_comb begin
    proc.proc_stall = req & (~in_idle | ~hit);
    proc.proc_rdata = '0;
    if (proc.proc_read && !proc.proc_stall)
      proc.proc_rdata = line_word(rd_line, word);
    mem.mem_read  = (state == S_ALLOC);
    mem.mem_write = (state == S_WB);
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (state == S_WB) begin
      mem.mem_addr  = {rd_tag, index};
      mem.mem_wdata = rd_line;
    end else if (state == S_ALLOC) begin
      mem.mem_addr  = {tag, index};
    end
  end

`ifdef DCACHE_STATS_EN
  logic refilled;

  // Event counters; the completion right after a fill is not a hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hit  <= '0;
      stat_miss <= '0;
      stat_wb   <= '0;
      refilled  <= 1'b0;
    end else begin
      if (in_idle && req && hit) begin
        if (!refilled) stat_hit <= stat_hit + 32'd1;
        refilled <= 1'b0;
      end
      if (fill_en) refilled <= 1'b1;
      if (in_idle && req && !hit) stat_miss <= stat_miss + 32'd1;
      if (clean_en) stat_wb <= stat_wb + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Directed scoreboard bench for dcache_wb with a latency-driven memory.
// Expected read words are queued at issue and popped at completion.
module tb_dcache_wb;

  logic clk;
  logic rst_n;

  dcache_proc_if pif ();
  dcache_mem_if  mif ();

`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hit;
  logic [31:0] stat_miss;
  logic [31:0] stat_wb;
`endif

  dcache_wb #(.NUM_LINES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .proc      (pif.slave),
    .mem       (mif.master)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hit  (stat_hit),
    .stat_miss (stat_miss),
    .stat_wb   (stat_wb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stalls, n_wb, n_rd, both_hi;
  bit wb_first;
  logic [27:0]  wb_addr, rd_addr;
  logic [127:0] wb_data;
  logic [31:0]  exp_q[$];

  localparam logic [127:0] L1 =
    {32'h33333333, 32'h22222222, 32'hA5A50001, 32'hDEADBEEF};
  localparam logic [127:0] L2 =
    {32'h0C0C0003, 32'h0C0C0002, 32'h0C0C0001, 32'h0C0C0000};
  localparam logic [127:0] L3 =
    {32'h25250003, 32'h25250002, 32'h25250001, 32'h25250000};
  localparam logic [127:0] L4 =
    {32'h48480003, 32'h48480002, 32'h48480001, 32'h48480000};

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds the request until stall drops.
  task automatic run_req(input string tag, input logic rd, input logic wr,
                         input logic [29:0] a, input logic [31:0] wd,
                         input int lat, input logic [127:0] fill,
                         input logic [31:0] exp_rd);
    int  cnt;
    bit  done;
    logic [31:0] exp_w;
    pif.proc_read  = rd;
    pif.proc_write = wr;
    pif.proc_addr  = a;
    pif.proc_wdata = wd;
    if (rd && !wr) exp_q.push_back(exp_rd);
    stalls = 0; n_wb = 0; n_rd = 0; wb_first = 0;
    cnt = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (mif.mem_read && mif.mem_write) both_hi++;
      if (mif.mem_read || mif.mem_write) begin
        cnt++;
        if (cnt == lat) begin
          cnt = 0;
          mif.mem_ready = 1'b1;
          mif.mem_rdata = fill;
          if (mif.mem_write) begin
            n_wb++;
            wb_addr = mif.mem_addr;
            wb_data = mif.mem_wdata;
            if (n_rd == 0) wb_first = 1;
          end else begin
            n_rd++;
            rd_addr = mif.mem_addr;
          end
        end
      end
      if (!pif.proc_stall) begin
        done = 1;
        if (rd && !wr) begin
          exp_w = exp_q.pop_front();
          check({tag, "_rdata"}, 128'(pif.proc_rdata), 128'(exp_w));
        end
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      mif.mem_ready = 1'b0;
      mif.mem_rdata = '0;
      @(negedge clk);
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s_timeout: observed stall expected completion", tag);
    end
    pif.proc_read  = 1'b0;
    pif.proc_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    both_hi = 0;
    pif.proc_read  = 1'b0;
    pif.proc_write = 1'b0;
    pif.proc_addr  = '0;
    pif.proc_wdata = '0;
    mif.mem_ready  = 1'b0;
    mif.mem_rdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_stall", 128'(pif.proc_stall), 128'(0));
    check("rst_mem_read", 128'(mif.mem_read), 128'(0));
    check("rst_mem_write", 128'(mif.mem_write), 128'(0));
    check("rst_rdata", 128'(pif.proc_rdata), 128'(0));
    check("rst_mem_addr", 128'(mif.mem_addr), 128'(0));
    check("rst_mem_wdata", mif.mem_wdata, 128'(0));
`ifdef DCACHE_STATS_EN
    check("rst_stat_hit", 128'(stat_hit), 128'(0));
`endif
    @(negedge clk);

    run_req("miss1", 1, 0, 30'h10, 0, 3, L1, 32'hDEADBEEF);
    check("miss1_stall", 128'(stalls), 128'(4));
    check("miss1_nwb", 128'(n_wb), 128'(0));
    check("miss1_nrd", 128'(n_rd), 128'(1));
    check("miss1_addr", 128'(rd_addr), 128'(28'h4));

    run_req("hit1", 1, 0, 30'h11, 0, 3, L1, 32'hA5A50001);
    check("hit1_stall", 128'(stalls), 128'(0));

    run_req("whit", 0, 1, 30'h10, 32'hCAFEBABE, 3, L1, 0);
    check("whit_stall", 128'(stalls), 128'(0));

    run_req("dmiss", 1, 0, 30'h30, 0, 2, L2, 32'h0C0C0000);
    check("dmiss_stall", 128'(stalls), 128'(5));
    check("dmiss_wbfirst", 128'(wb_first), 128'(1));
    check("dmiss_wbaddr", 128'(wb_addr), 128'(28'h4));
    check("dmiss_wbdata", wb_data,
          {32'h33333333, 32'h22222222, 32'hA5A50001, 32'hCAFEBABE});
    check("dmiss_rdaddr", 128'(rd_addr), 128'(28'hC));

    run_req("wmiss", 0, 1, 30'h25, 32'h12345678, 1, L3, 0);
    check("wmiss_stall", 128'(stalls), 128'(2));
    check("wmiss_nwb", 128'(n_wb), 128'(0));
    check("wmiss_addr", 128'(rd_addr), 128'(28'h9));
`ifdef DCACHE_STATS_EN
    check("stat_hit", 128'(stat_hit), 128'(2));
    check("stat_miss", 128'(stat_miss), 128'(3));
    check("stat_wb", 128'(stat_wb), 128'(1));
`endif

    run_req("merge", 1, 0, 30'h25, 0, 1, L3, 32'h12345678);
    check("merge_stall", 128'(stalls), 128'(0));
    run_req("neigh", 1, 0, 30'h24, 0, 1, L3, 32'h25250000);
    check("neigh_stall", 128'(stalls), 128'(0));

    mif.mem_ready = 1'b1;
    mif.mem_rdata = L4;
    @(posedge clk);
    #1;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    @(negedge clk);
    run_req("idlerdy", 1, 0, 30'h31, 0, 3, L4, 32'h0C0C0001);
    check("idlerdy_stall", 128'(stalls), 128'(0));

    pif.proc_read = 1'b1;
    pif.proc_addr = 30'h48;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      #1;
      if (mif.mem_read) seen = 1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    check("alloc_seen", 128'(seen), 128'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_drop", 128'(mif.mem_read), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_req("reread", 1, 0, 30'h48, 0, 2, L4, 32'h48480000);
    check("reread_stall", 128'(stalls), 128'(3));
`ifdef DCACHE_STATS_EN
    check("rst_stat_miss", 128'(stat_miss), 128'(1));
    check("rst_stat_hit2", 128'(stat_hit), 128'(0));
`endif
    check("both_high", 128'(both_hi), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
